register_display_pager: RTL
===========================

Name: register_display_pager

Overview:
- Feeds the VGA register-heap renderer, which can draw four 16-bit registers at once.
- Captures a tear-free snapshot of the CPU register bus once per frame, on the vsync rising edge.
- Selects a four-register page to show. The page advances on a debounced button press or automatically every AUTO_FRAMES frames.
- Sits between the CPU register file export and the renderer instance, in the pixel-clock domain.

Parameters:
- NUM_REGS, 11: number of 16-bit registers on regs_in. Register 0 occupies the MSBs. Valid range 1..16.
- AUTO_FRAMES, 120: frames per automatic page advance. Must be at least 1.
- DEBOUNCE_CYCLES, 500000: number of clk cycles btn_next must remain stable before it is accepted.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- regs_in  in  16*NUM_REGS  live register bus; reg i = regs_in[16*(NUM_REGS-i)-1 -: 16]
- vsync  in  1  frame sync, level; its rising edge marks the frame boundary
- btn_next  in  1  raw button, active-high, asynchronous to clk
- auto_en  in  1  enables automatic paging
- freeze  in  1  when 1, the snapshot is not refreshed; page changes still apply
- window  out  64  four registers of the current page; slot 0 in [63:48]
- base_idx  out  4  index of the register in slot 0
- slot_valid  out  4  bit k (k=3 is slot 0) set when slot k maps to an existing register
- page  out  2  current page number
- update  out  1  one-cycle pulse in the cycle the outputs change at a frame edge

Behaviour:
- NUM_PAGES = ceil(NUM_REGS/4); page ranges 0..NUM_PAGES-1.
- Reset (rst=0, asynchronous), all outputs and state cleared:
  - page=0, base_idx=0, window=0, update=0.
  - slot_valid = mask for page 0; 4'b1111 if NUM_REGS≥4.
  - Snapshot register=0, pending=0, frame counter=0, debouncer in IDLE.
- Input synchronisation: btn_next and vsync each pass through a 2-flop synchroniser. The vsync rising edge is detected on the synchronised signal; the resulting pulse is `edge`.
- Debouncer FSM on the synchronised button:
  - IDLE: on 1, go to PRESS_WAIT and clear the counter.
  - PRESS_WAIT: count while the button is 1. On reaching DEBOUNCE_CYCLES, go to HELD and assert a one-cycle `btn_evt`. If the button returns to 0 first, go back to IDLE.
  - HELD: on 0, go to RELEASE_WAIT and clear the counter.
  - RELEASE_WAIT: count while the button is 0. On reaching DEBOUNCE_CYCLES, go to IDLE. If the button returns to 1 first, go back to HELD.
  - Exactly one btn_evt per accepted press; no auto-repeat.
- Frame counter:
  - Increments on each `edge` while auto_en=1; held at 0 while auto_en=0.
  - When it reaches AUTO_FRAMES-1 on an `edge`, it wraps to 0 and sets pending.
  - It is also cleared whenever a page change is applied.
- pending:
  - Set by btn_evt or by auto expiry. Multiple requests before the next edge merge into a single advance.
  - Cleared on `edge`.
- On `edge`, all outputs are registered together and take effect 1 clk after `edge`:
  - If pending: page ← (page==NUM_PAGES-1) ? 0 : page+1.
  - If freeze=0: snapshot ← regs_in. The snapshot is taken on the same cycle as the page update.
  - window, base_idx=4*page, slot_valid recomputed from the new page and snapshot.
  - Unused slots (index ≥ NUM_REGS) output 16'h0000 with their valid bit cleared.
  - update=1 for that single cycle.
- Simultaneous events:
  - btn_evt in the same cycle as `edge`: the event sets pending for the next frame and does not affect the current edge.
  - Auto expiry and a button press in the same frame produce a single advance.
- Outputs never change except on `edge` or reset. Changing regs_in between edges has no visible effect.
- Reset asserted mid-debounce or mid-frame: all state is cleared immediately. After reset releases, the first edge loads the snapshot on page 0.

Test Plan:
- Bench parameters: NUM_REGS=11, AUTO_FRAMES=3, DEBOUNCE_CYCLES=4.
- Snapshot: after reset, set regs_in so reg i = 16'h1000+i, then pulse vsync → update pulses once; window=64'h1000_1001_1002_1003, base_idx=0, slot_valid=4'b1111. Change regs_in without a vsync → window unchanged.
- Button paging with wrap-around and tail page:
  - Press btn_next for 10 cycles, release, then vsync → page=1, base_idx=4, window=64'h1004_1005_1006_1007.
  - Press again, then vsync → page=2; window=64'h1008_1009_100A_0000, slot_valid=4'b1110.
  - Press again, then vsync → page=0.
- Bounce rejection: toggle btn_next 1,0,1,0 each cycle for 20 cycles, then apply a vsync → page unchanged. Two clean presses within one frame → only one advance.
- Auto paging: auto_en=1 with 6 vsync edges → page advances on edge 3 (to 1) and edge 6 (to 2). Set auto_en=0 → no further advances over 10 edges.
- Freeze: set freeze=1, change regs_in, press the button, then vsync → page advances but window shows the old snapshot values for the new page.
- Reset mid-operation: assert rst=0 during PRESS_WAIT with pending set → all outputs go to reset values immediately. After release, a vsync gives page=0 and no advance.

Source files
------------

// File: rtl/register_display_pager.sv
// Pages four 16-bit registers at a time out of a CPU register bus for the VGA renderer.
// Once per frame, on the vsync rising edge, it takes a snapshot of the bus and applies any pending page advance.
module register_display_pager #(
  parameter int NUM_REGS        = 11,
  parameter int AUTO_FRAMES     = 120,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [16*NUM_REGS-1:0]  regs_in,
  input  logic                    vsync,
  input  logic                    btn_next,
  input  logic                    auto_en,
  input  logic                    freeze,
  output logic [63:0]             window,
  output logic [3:0]              base_idx,
  output logic [3:0]              slot_valid,
  output logic [1:0]              page,
  output logic                    update
);

  localparam int NUM_PAGES = (NUM_REGS + 3) / 4;
  localparam logic [1:0] LAST_PAGE = 2'(NUM_PAGES - 1);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam int FCW = $clog2(AUTO_FRAMES + 1);
  localparam logic [FCW-1:0] AF_LAST = FCW'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

  function automatic logic [3:0] valid_mask(input logic [1:0] pg);
    logic [3:0] m;
    m = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      m[3-k] = ((4 * int'(pg) + k) < NUM_REGS);
    end
    return m;
  endfunction

  db_state_t               db_state_q, db_state_d;
  logic [DCW-1:0]          db_cnt_q, db_cnt_d;
  logic [1:0]              btn_sync_q, btn_sync_d;
  logic [2:0]              vs_sync_q, vs_sync_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic                    pending_q, pending_d;
  logic [16*NUM_REGS-1:0]  snap_q, snap_d;
  logic [1:0]              page_q, page_d;
  logic [63:0]             window_q, window_d;
  logic [3:0]              base_idx_q, base_idx_d;
  logic [3:0]              slot_valid_q, slot_valid_d;
  logic                    update_q, update_d;

  logic                    btn_s, vs_edge_s, btn_evt_s, adv_s;
  logic [1:0]              page_n_s;
  logic [16*NUM_REGS-1:0]  snap_n_s;
  logic [63:0]             win_s;

  assign btn_s     = btn_sync_q[1];
  assign vs_edge_s = vs_sync_q[1] & ~vs_sync_q[2];

  // Button debouncer: accept a level only after it has been stable for DEBOUNCE_CYCLES.
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = db_cnt_q;
    btn_evt_s  = 1'b0;
    case (db_state_q)
      IDLE: begin
        if (btn_s) begin
          db_state_d = PRESS_WAIT;
          db_cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          db_state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          db_state_d = HELD;
          btn_evt_s  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          db_state_d = RELEASE_WAIT;
          db_cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          db_state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          db_state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: db_state_d = IDLE;
    endcase
  end

  // Frame bookkeeping; an auto expiry applies on the edge that detects it and merges with a pending press.
  always_comb begin
    btn_sync_d = {btn_sync_q[0], btn_next};
    vs_sync_d  = {vs_sync_q[1:0], vsync};
    adv_s      = vs_edge_s & (pending_q | (auto_en & (fcnt_q == AF_LAST)));
    pending_d  = (pending_q & ~vs_edge_s) | btn_evt_s;
    if (!auto_en || adv_s) begin
      fcnt_d = '0;
    end else if (vs_edge_s) begin
      fcnt_d = fcnt_q + 1'b1;
    end else begin
      fcnt_d = fcnt_q;
    end
    if (adv_s) begin
      page_n_s = (page_q == LAST_PAGE) ? 2'd0 : page_q + 2'd1;
    end else begin
      page_n_s = page_q;
    end
    snap_n_s = (vs_edge_s && !freeze) ? regs_in : snap_q;
  end

  // Window built from the next page and snapshot so every output moves in the same cycle.
  always_comb begin
    win_s = 64'h0;
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        win_s[16*(3-k) +: 16] = win_s[16*(3-k) +: 16] |
          (((4 * int'(page_n_s) + k) == r) ? snap_n_s[16*(NUM_REGS-1-r) +: 16] : 16'h0000);
      end
    end
    snap_d   = snap_n_s;
    page_d   = page_n_s;
    update_d = vs_edge_s;
    if (vs_edge_s) begin
      window_d     = win_s;
      base_idx_d   = {page_n_s, 2'b00};
      slot_valid_d = valid_mask(page_n_s);
    end else begin
      window_d     = window_q;
      base_idx_d   = base_idx_q;
      slot_valid_d = slot_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_state_q   <= IDLE;
      db_cnt_q     <= '0;
      btn_sync_q   <= 2'b00;
      vs_sync_q    <= 3'b000;
      fcnt_q       <= '0;
      pending_q    <= 1'b0;
      snap_q       <= '0;
      page_q       <= 2'd0;
      window_q     <= 64'h0;
      base_idx_q   <= 4'd0;
      slot_valid_q <= valid_mask(2'd0);
      update_q     <= 1'b0;
    end else begin
      db_state_q   <= db_state_d;
      db_cnt_q     <= db_cnt_d;
      btn_sync_q   <= btn_sync_d;
      vs_sync_q    <= vs_sync_d;
      fcnt_q       <= fcnt_d;
      pending_q    <= pending_d;
      snap_q       <= snap_d;
      page_q       <= page_d;
      window_q     <= window_d;
      base_idx_q   <= base_idx_d;
      slot_valid_q <= slot_valid_d;
      update_q     <= update_d;
    end
  end

  assign window     = window_q;
  assign base_idx   = base_idx_q;
  assign slot_valid = slot_valid_q;
  assign page       = page_q;
  assign update     = update_q;

endmodule
